// File: rtl/flu_fp32.sv
// flu_fp32: binary32 add/sub/mul/div/fmod/sqrt with truncating rounding.
// Denormals are flushed to zero and any e==255 input yields the canonical NaN; all outputs are registered.
module flu_fp32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        s,
   input  logic [7:0]  e,
   input  logic [22:0] m,
   input  logic        s0,
   input  logic [7:0]  e0,
   input  logic [22:0] m0,
   output logic [31:0] op,
   output logic [31:0] op0,
   output logic [31:0] add1,
   output logic [31:0] sub1,
   output logic [31:0] mul1,
   output logic [31:0] quo1,
   output logic [31:0] rem1,
   output logic [31:0] sr1
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   function automatic logic signed [11:0] ext8(input logic [7:0] v);
      return $signed({4'b0, v});
   endfunction

   function automatic logic signed [11:0] ext5(input logic [4:0] v);
      return $signed({7'b0, v});
   endfunction

   function automatic logic [31:0] pack(input logic sg, input logic signed [11:0] ex,
                                        input logic [22:0] fr);
      logic [31:0] r;
      if (ex >= 12'sd255)    r = {sg, 8'hFF, 23'h0};
      else if (ex <= 12'sd0) r = {sg, 31'h0};
      else                   r = {sg, ex[7:0], fr};
      return r;
   endfunction

   function automatic logic [4:0] lzc24(input logic [23:0] v);
      logic [4:0] n;
      n = 5'd24;
      for (int i = 0; i < 24; i++)
         if (v[i]) n = 5'(23 - i);
      return n;
   endfunction

   function automatic logic [31:0] fadd(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                                        input logic sb, input logic [7:0] eb, input logic [22:0] mb);
      logic        a_big, sg;
      logic [7:0]  ex_b, ex_s, diff;
      logic [23:0] sig_l, sig_s, shf, dif;
      logic [24:0] sum;
      logic [4:0]  lz;
      logic [31:0] r;
      a_big = {ea, ma} >= {eb, mb};
      sg    = a_big ? sa : sb;
      ex_b  = a_big ? ea : eb;
      ex_s  = a_big ? eb : ea;
      sig_l = {1'b1, a_big ? ma : mb};
      sig_s = {1'b1, a_big ? mb : ma};
      diff  = ex_b - ex_s;
      shf   = (diff >= 8'd25) ? 24'd0 : (sig_s >> diff);
      sum   = {1'b0, sig_l} + {1'b0, shf};
      dif   = sig_l - shf;
      lz    = lzc24(dif);
      if (ea == 8'd0)      r = (eb == 8'd0) ? 32'h0 : {sb, eb, mb};
      else if (eb == 8'd0) r = {sa, ea, ma};
      else if (sa == sb)   r = sum[24] ? pack(sg, ext8(ex_b) + 12'sd1, sum[23:1])
                                       : pack(sg, ext8(ex_b), sum[22:0]);
      else if (dif == 24'd0) r = 32'h0;
      else                 r = pack(sg, ext8(ex_b) - ext5(lz), 23'(dif << lz));
      return r;
   endfunction

   // Long-division remainder: one compare/subtract per exponent step, doubling between steps.
   function automatic logic [23:0] frem_core(input logic [23:0] sa, input logic [23:0] sb,
                                             input logic [7:0] diff);
      logic [24:0] r;
      r = {1'b0, sa};
      for (int i = 0; i < 25; i++) begin
         if (i <= int'(diff)) begin
            if (r >= {1'b0, sb}) r = r - {1'b0, sb};
            if (i < int'(diff))  r = {r[23:0], 1'b0};
         end
      end
      return r[23:0];
   endfunction

   function automatic logic [22:0] isqrt48(input logic [47:0] rad);
      logic [26:0] rem_v, trial;
      logic [23:0] root;
      rem_v = '0;
      root  = '0;
      for (int i = 23; i >= 0; i--) begin
         rem_v = {rem_v[24:0], rad[2*i +: 2]};
         trial = {1'b0, root, 2'b01};
         if (rem_v >= trial) begin
            rem_v = rem_v - trial;
            root  = {root[22:0], 1'b1};
         end else begin
            root  = {root[22:0], 1'b0};
         end
      end
      return root[22:0];
   endfunction

   logic [23:0]        sig_a, sig_b, rfin;
   logic               za, zb, spec, sx;
   logic [24:0]        prod_hi, q;
   logic signed [11:0] mex, qex, ue, sex;
   logic [7:0]         rdiff;
   logic [4:0]         rlz;
   logic [22:0]        rnorm, root;
   logic [47:0]        rad;

   assign sig_a   = {1'b1, m};
   assign sig_b   = {1'b1, m0};
   assign za      = (e == 8'd0);
   assign zb      = (e0 == 8'd0);
   assign spec    = (e == 8'hFF) | (e0 == 8'hFF);
   assign sx      = s ^ s0;
   assign prod_hi = 25'(({24'h0, sig_a} * {24'h0, sig_b}) >> 23);
   assign mex     = ext8(e) + ext8(e0) - 12'sd127;
   assign q       = 25'({sig_a, 24'h0} / {24'h0, sig_b});
   assign qex     = ext8(e) - ext8(e0) + 12'sd127;
   assign rdiff   = e - e0;
   assign rfin    = frem_core(sig_a, sig_b, rdiff);
   assign rlz     = lzc24(rfin);
   assign rnorm   = 23'(rfin << rlz);
   // An odd unbiased exponent folds one factor of two into the radicand.
   assign ue      = ext8(e) - 12'sd127;
   assign rad     = ue[0] ? {sig_a, 24'h0} : {1'b0, sig_a, 23'h0};
   assign sex     = (ue >>> 1) + 12'sd127;
   assign root    = isqrt48(rad);

   logic [31:0] op_d, op0_d, add_d, sub_d, mul_d, quo_d, rem_d, sr_d;
   logic [31:0] op_q, op0_q, add_q, sub_q, mul_q, quo_q, rem_q, sr_q;

   always_comb begin
      op_d  = {s, e, m};
      op0_d = {s0, e0, m0};
      add_d = fadd(s, e, m, s0, e0, m0);
      sub_d = fadd(s, e, m, ~s0, e0, m0);

      if (za | zb)          mul_d = {sx, 31'h0};
      else if (prod_hi[24]) mul_d = pack(sx, mex + 12'sd1, prod_hi[23:1]);
      else                  mul_d = pack(sx, mex, prod_hi[22:0]);

      if (zb)               quo_d = za ? QNAN : {sx, 8'hFF, 23'h0};
      else if (za)          quo_d = {sx, 31'h0};
      else if (q[24])       quo_d = pack(sx, qex, q[23:1]);
      else                  quo_d = pack(sx, qex - 12'sd1, q[22:0]);

      if (zb)                   rem_d = QNAN;
      else if (za)              rem_d = {s, 31'h0};
      else if (e < e0)          rem_d = {s, e, m};
      else if (rdiff > 8'd24)   rem_d = 32'h0;
      else if (rfin == 24'h0)   rem_d = {s, 31'h0};
      else                      rem_d = pack(s, ext8(e0) - ext5(rlz), rnorm);

      if (za)               sr_d = {s, 31'h0};
      else if (s)           sr_d = QNAN;
      else                  sr_d = pack(1'b0, sex, root);

      if (spec) begin
         add_d = QNAN;
         sub_d = QNAN;
         mul_d = QNAN;
         quo_d = QNAN;
         rem_d = QNAN;
         sr_d  = QNAN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q  <= '0;
         op0_q <= '0;
         add_q <= '0;
         sub_q <= '0;
         mul_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         sr_q  <= '0;
      end else begin
         op_q  <= op_d;
         op0_q <= op0_d;
         add_q <= add_d;
         sub_q <= sub_d;
         mul_q <= mul_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         sr_q  <= sr_d;
      end
   end

   assign op   = op_q;
   assign op0  = op0_q;
   assign add1 = add_q;
   assign sub1 = sub_q;
   assign mul1 = mul_q;
   assign quo1 = quo_q;
   assign rem1 = rem_q;
   assign sr1  = sr_q;

endmodule

// File: tb/tb_flu_fp32.sv
// Bench for flu_fp32: hand-derived vectors, queue scoreboard, reset hold/release and mid-cycle reset.
module tb_flu_fp32;

   logic        clk = 1'b0;
   logic        rst;
   logic        s, s0;
   logic [7:0]  e, e0;
   logic [22:0] m, m0;
   logic [31:0] op, op0, add1, sub1, mul1, quo1, rem1, sr1;

   always #5 clk = ~clk;

   flu_fp32 dut (
      .clk(clk), .rst(rst),
      .s(s), .e(e), .m(m), .s0(s0), .e0(e0), .m0(m0),
      .op(op), .op0(op0), .add1(add1), .sub1(sub1),
      .mul1(mul1), .quo1(quo1), .rem1(rem1), .sr1(sr1)
   );

   logic [31:0] obs [8];
   assign obs[0] = op;
   assign obs[1] = op0;
   assign obs[2] = add1;
   assign obs[3] = sub1;
   assign obs[4] = mul1;
   assign obs[5] = quo1;
   assign obs[6] = rem1;
   assign obs[7] = sr1;

   string oname [8] = '{"op", "op0", "add1", "sub1", "mul1", "quo1", "rem1", "sr1"};

   int checks = 0;
   int errors = 0;

   localparam int NV = 11;
   // Row layout: A, B, A+B, A-B, A*B, A/B, fmod(A,B), sqrt(A); op/op0 must equal A/B.
   logic [31:0] tbl [NV][8];
   logic [31:0] tmk [NV][8];
   string       tname [NV];

   typedef struct {
      string            name;
      logic [7:0][31:0] ev;
      logic [7:0][31:0] mk;
   } sb_t;
   sb_t sbq [$];

   task automatic set_row(input int i, input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ad, input logic [31:0] sb, input logic [31:0] mu,
                          input logic [31:0] qu, input logic [31:0] re, input logic [31:0] sq);
      tname[i]  = nm;
      tbl[i][0] = a;  tbl[i][1] = b;  tbl[i][2] = ad; tbl[i][3] = sb;
      tbl[i][4] = mu; tbl[i][5] = qu; tbl[i][6] = re; tbl[i][7] = sq;
      for (int k = 0; k < 8; k++) tmk[i][k] = 32'hFFFFFFFF;
   endtask

   task automatic load_tables();
      set_row(0,  "simple",  32'h40000000, 32'h3FC00000, 32'h40600000, 32'h3F000000,
                             32'h40400000, 32'h3FAAAAAA, 32'h3F000000, 32'h3FB504F3);
      set_row(1,  "gap",     32'hB5DD9C52, 32'h59B7CC9B, 32'h59B7CC9B, 32'hD9B7CC9B,
                             32'hD0000000, 32'h9B800000, 32'hB5DD9C52, 32'h7FC00000);
      tmk[1][4] = 32'hFF800000;
      tmk[1][5] = 32'hFF800000;
      set_row(2,  "ones",    32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00000000,
                             32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000);
      set_row(3,  "divzero", 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                             32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000);
      set_row(4,  "inf_a",   32'h7F800000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000,
                             32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000);
      set_row(5,  "ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 32'h00000000,
                             32'h7F800000, 32'h3F800000, 32'h00000000, 32'h5F3504F3);
      set_row(6,  "unf",     32'h00800000, 32'h7F000000, 32'h7F000000, 32'hFF000000,
                             32'h40000000, 32'h00000000, 32'h00800000, 32'h20000000);
      set_row(7,  "bigexp",  32'h50000000, 32'h3F800000, 32'h50000000, 32'h50000000,
                             32'h50000000, 32'h50000000, 32'h00000000, 32'h47B504F3);
      set_row(8,  "neg",     32'hC0400000, 32'h40000000, 32'hBF800000, 32'hC0A00000,
                             32'hC0C00000, 32'hBFC00000, 32'hBF800000, 32'h7FC00000);
      set_row(9,  "zeros",   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                             32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h00000000);
      set_row(10, "nan_b",   32'h3F800000, 32'hFFC00000, 32'h7FC00000, 32'h7FC00000,
                             32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000);
   endtask

   task automatic drive_row(input int i);
      sb_t ent;
      {s, e, m}    = tbl[i][0];
      {s0, e0, m0} = tbl[i][1];
      ent.name = tname[i];
      for (int k = 0; k < 8; k++) begin
         ent.ev[k] = tbl[i][k];
         ent.mk[k] = tmk[i][k];
      end
      sbq.push_back(ent);
   endtask

   task automatic test_reset();
      sb_t ent;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         {s, e, m}    = $urandom;
         {s0, e0, m0} = $urandom;
         #1;
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs[k] !== 32'h0) begin
               errors++;
               $display("FAIL reset_hold %s got=%h exp=00000000", oname[k], obs[k]);
            end
         end
      end
      @(negedge clk);
      rst = 1'b0;
      drive_row(0);
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs[k] !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_pre_edge %s got=%h exp=00000000", oname[k], obs[k]);
         end
      end
      @(posedge clk);
      #1;
      ent = sbq.pop_front();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ((obs[k] & ent.mk[k]) !== (ent.ev[k] & ent.mk[k])) begin
            errors++;
            $display("FAIL reset_first_edge %s got=%h exp=%h", oname[k], obs[k], ent.ev[k]);
         end
      end
      $display("txn reset_release %s", ent.name);
   endtask

   task automatic test_back_to_back();
      sb_t ent;
      int  idx;
      for (int n = 0; n < NV + 12; n++) begin
         idx = (n < NV) ? n : int'($urandom_range(NV - 1, 0));
         @(negedge clk);
         drive_row(idx);
         @(posedge clk);
         #1;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL b2b_queue_empty got=0 exp=1");
         end else begin
            ent = sbq.pop_front();
            for (int k = 0; k < 8; k++) begin
               checks++;
               if ((obs[k] & ent.mk[k]) !== (ent.ev[k] & ent.mk[k])) begin
                  errors++;
                  $display("FAIL b2b_%s %s got=%h exp=%h", ent.name, oname[k], obs[k], ent.ev[k]);
               end
            end
            $display("txn b2b %0d %s", n, ent.name);
         end
      end
   endtask

   task automatic test_reset_mid();
      sb_t ent;
      @(negedge clk);
      drive_row(2);
      @(posedge clk);
      #1;
      ent = sbq.pop_front();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ((obs[k] & ent.mk[k]) !== (ent.ev[k] & ent.mk[k])) begin
            errors++;
            $display("FAIL mid_pre %s got=%h exp=%h", oname[k], obs[k], ent.ev[k]);
         end
      end
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs[k] !== 32'h0) begin
            errors++;
            $display("FAIL mid_async_clear %s got=%h exp=00000000", oname[k], obs[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      drive_row(5);
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs[k] !== 32'h0) begin
            errors++;
            $display("FAIL mid_hold_until_edge %s got=%h exp=00000000", oname[k], obs[k]);
         end
      end
      @(posedge clk);
      #1;
      ent = sbq.pop_front();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ((obs[k] & ent.mk[k]) !== (ent.ev[k] & ent.mk[k])) begin
            errors++;
            $display("FAIL mid_post %s got=%h exp=%h", oname[k], obs[k], ent.ev[k]);
         end
      end
      $display("txn reset_mid %s", ent.name);
   endtask

   initial begin
      rst = 1'b1;
      {s, e, m}    = 32'h0;
      {s0, e0, m0} = 32'h0;
      load_tables();
      test_reset();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
